// File: rtl/wb_stream_arbiter.sv
// wb_stream_arbiter: two-requester Wishbone arbiter onto one shared slave port, alternating on ties.
// Define WB_STREAM_ARBITER_TIMEOUT_EN to compile in the ack watchdog (err + timeout_o pulse on a stalled slave).
module wb_stream_arbiter #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WB_AW-1:0]   m0_adr_i,
  input  logic [WB_DW-1:0]   m0_dat_i,
  input  logic [WB_DW/8-1:0] m0_sel_i,
  input  logic               m0_we_i,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic [2:0]         m0_cti_i,
  input  logic [1:0]         m0_bte_i,
  output logic [WB_DW-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic               m0_rty_o,
  input  logic [WB_AW-1:0]   m1_adr_i,
  input  logic [WB_DW-1:0]   m1_dat_i,
  input  logic [WB_DW/8-1:0] m1_sel_i,
  input  logic               m1_we_i,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic [2:0]         m1_cti_i,
  input  logic [1:0]         m1_bte_i,
  output logic [WB_DW-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               m1_rty_o,
  output logic [WB_AW-1:0]   s_adr_o,
  output logic [WB_DW-1:0]   s_dat_o,
  output logic [WB_DW/8-1:0] s_sel_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  input  logic [WB_DW-1:0]   s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_rty_i,
  output logic               timeout_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic g0, g1, stb_raw, hit;
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_stream_arbiter: TIMEOUT must be in 1..65535");
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
  // The grant is only released when the owner's cyc samples low, so bursts stay atomic.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (m0_cyc_i && m1_cyc_i) ? (last_q ? GNT0 : GNT1) :
                m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (state_q == GNT0 && !m0_cyc_i)
      state_d = m1_cyc_i ? GNT1 : IDLE;
    else if (state_q == GNT1 && !m1_cyc_i)
      state_d = m0_cyc_i ? GNT0 : IDLE;
    last_d = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : last_q;
  end
  always_comb begin
    g0       = state_q == GNT0;
    g1       = state_q == GNT1;
    stb_raw  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    s_cti_o  = g0 ? m0_cti_i : g1 ? m1_cti_i : '0;
    s_bte_o  = g0 ? m0_bte_i : g1 ? m1_bte_i : '0;
    s_stb_o  = stb_raw && !hit;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = g0 && s_ack_i;
    m0_err_o = g0 && (s_err_i || hit);
    m0_rty_o = g0 && s_rty_i;
    m1_ack_o = g1 && s_ack_i;
    m1_err_o = g1 && (s_err_i || hit);
    m1_rty_o = g1 && s_rty_i;
  end
`ifdef WB_STREAM_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic stalled;
  // cnt_q holds the number of earlier consecutive stalled cycles, so the abort lands on stalled cycle TIMEOUT.
  always_comb begin
    stalled   = stb_raw && !(s_ack_i || s_err_i || s_rty_i);
    hit       = stalled && cnt_q == 16'(TIMEOUT - 1);
    cnt_d     = (stalled && !hit) ? cnt_q + 16'd1 : 16'd0;
    timeout_o = hit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign hit       = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stream_arbiter.sv
// tb_wb_stream_arbiter: directed scenarios plus random traffic checked against a grant-owner model.
module tb_wb_stream_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [31:0] adr[2], dat[2];
  logic [3:0]  sel[2];
  logic        we[2], cyc[2], stb[2];
  logic [2:0]  cti[2];
  logic [1:0]  bte[2];
  logic [31:0] sdat;
  logic        sack, serr, srty;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic s_we_o, s_cyc_o, s_stb_o, timeout_o;
  int g, last, stall, checks, failures;
  bit wd_en;

  wb_stream_arbiter #(.WB_AW(32), .WB_DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_cti_i(cti[0]), .m0_bte_i(bte[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_cti_i(cti[1]), .m1_bte_i(bte[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr), .s_rty_i(srty), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit hit_exp();
    return wd_en && g >= 0 && stb[g] && !(sack || serr || srty) && stall == TO - 1;
  endfunction

  task automatic model_reset();
    g = -1; last = 1; stall = 0;
  endtask

  task automatic check_all();
    bit h;
    int gi;
    logic [75:0] eb;
    h  = hit_exp();
    gi = g < 0 ? 0 : g;
    eb = g < 0 ? '0 : {adr[gi], dat[gi], sel[gi], we[gi], cyc[gi], stb[gi] && !h, cti[gi], bte[gi]};
    chk("s_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}, eb);
    chk("m0_resp", {m0_ack_o, m0_err_o, m0_rty_o}, g == 0 ? {sack, serr || h, srty} : 3'b0);
    chk("m1_resp", {m1_ack_o, m1_err_o, m1_rty_o}, g == 1 ? {sack, serr || h, srty} : 3'b0);
    chk("m_dat", {m0_dat_o, m1_dat_o}, {sdat, sdat});
    chk("timeout", timeout_o, h);
  endtask

  // Owner changes only when the current owner has dropped cyc; ties go to whoever did not own last.
  task automatic model_update();
    bit h;
    int ng;
    if (rst) begin model_reset(); return; end
    h = hit_exp();
    stall = (g >= 0 && stb[g] && !(sack || serr || srty) && !h) ? stall + 1 : 0;
    ng = g;
    if (g < 0) ng = (cyc[0] && cyc[1]) ? 1 - last : cyc[0] ? 0 : cyc[1] ? 1 : -1;
    else if (!cyc[g]) ng = cyc[1 - g] ? 1 - g : -1;
    if (ng != g) stall = 0;
    if (ng >= 0) last = ng;
    g = ng;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rnd_fields(input int n);
    adr[n] = $urandom; dat[n] = $urandom; sel[n] = 4'($urandom);
    we[n] = 1'($urandom); cti[n] = 3'($urandom); bte[n] = 2'($urandom);
  endtask

  initial begin
    checks = 0; failures = 0;
`ifdef WB_STREAM_ARBITER_TIMEOUT_EN
    wd_en = 1'b1;
`else
    wd_en = 1'b0;
`endif
    for (int n = 0; n < 2; n++) begin
      adr[n] = '0; dat[n] = '0; sel[n] = '0; we[n] = 1'b0;
      cyc[n] = 1'b0; stb[n] = 1'b0; cti[n] = '0; bte[n] = '0;
    end
    sdat = 32'hA5A5_0001; sack = 1'b0; serr = 1'b0; srty = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, timeout_o}, 5'b0);
    step();
    rst = 1'b0;
    // single read by m0, slave acks on the second granted cycle
    adr[0] = 32'h0000_1000; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
    chk("rd_no_grant_yet", s_cyc_o, 1'b0);
    step();
    chk("rd_grant", s_cyc_o, 1'b1);
    step();
    sack = 1'b1; sdat = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack", {m0_ack_o, m1_ack_o, m0_dat_o}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    step();
    sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    // simultaneous requests alternate
    adr[0] = 32'h0000_00A0; adr[1] = 32'h0000_00B0;
    cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b1;
    step();
    chk("tie_first_m0", s_adr_o, 32'h0000_00A0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    chk("tie_then_m1", s_adr_o, 32'h0000_00B0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    step();
    cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b1;
    step();
    chk("tie_again_m0", s_adr_o, 32'h0000_00A0);
    cyc[0] = 1'b0; cyc[1] = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
    step();
    // m1 8-beat incrementing burst while m0 waits
    cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; bte[1] = 2'b00; adr[1] = 32'h0000_2000;
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_1000;
    for (int b = 0; b < 8; b++) begin
      adr[1] = 32'h0000_2000 + 32'(b * 4);
      cti[1] = b == 7 ? 3'b111 : 3'b010;
      sack = 1'b1; sdat = $urandom;
      #1;
      chk("burst_hold", {s_cyc_o, s_adr_o, m1_ack_o, m0_ack_o}, {1'b1, adr[1], 1'b1, 1'b0});
      step();
    end
    sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cti[1] = '0;
    step();
    chk("burst_then_m0", {s_cyc_o, s_adr_o}, {1'b1, 32'h0000_1000});
    // asynchronous reset in the middle of an m1 burst
    cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010;
    step();
    sack = 1'b1;
    step();
    chk("pre_rst_m1", {s_cyc_o, s_adr_o}, {1'b1, adr[1]});
    rst = 1'b1;
    #1;
    chk("rst_async_cyc", {s_cyc_o, s_stb_o}, 2'b00);
    model_reset();
    sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_m0", {s_cyc_o, s_adr_o}, {1'b1, 32'h0000_1000});
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    // stalled slave: watchdog fires on stalled cycle TO only when compiled in
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) begin
      chk("stall_err", {m0_err_o, timeout_o, s_stb_o},
          (wd_en && k == TO) ? 3'b110 : 3'b001);
      step();
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        cyc[n] = cyc[n] ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
        stb[n] = cyc[n] ? ($urandom_range(3) != 0) : 1'($urandom);
        rnd_fields(n);
      end
      sdat = $urandom;
      sack = $urandom_range(2) == 0;
      serr = $urandom_range(15) == 0;
      srty = $urandom_range(15) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
